// File: rtl/lvt_write_scheduler_if.sv
// Request/port bundle between requesters, the LVT write scheduler and the LVT memory write ports.
// No logic and no latency. Backpressure is carried by req_ready. The memory ports take no backpressure.
// The slave modport is the scheduler's view. The master modport is the requester/memory side.
interface lvt_write_scheduler_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int PORTS = 2,
    parameter int REQS  = 4
);
    localparam int AW = $clog2(DEPTH);

    logic [REQS-1:0]        req_valid;
    logic [REQS*AW-1:0]     req_addr;
    logic [REQS*WIDTH-1:0]  req_data;
    logic [REQS-1:0]        req_ready;
    logic [PORTS-1:0]       mem_en;
    logic [PORTS*AW-1:0]    mem_addr;
    logic [PORTS*WIDTH-1:0] mem_d;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, mem_en, mem_addr, mem_d
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, mem_en, mem_addr, mem_d
    );
endinterface

// File: rtl/lvt_write_scheduler.sv
// Clears the LVT after reset, then grants up to PORTS requesters per cycle, round-robin, onto the memory write ports.
// Latency: a grant in cycle N drives the memory port registers in cycle N+1.
// Backpressure: req_ready is combinational. The memory ports never stall. LVT_SCHED_STATS_EN enables the conflict counter.
module lvt_write_scheduler #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int PORTS = 2,
    parameter int REQS  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    lvt_write_scheduler_if.slave        bus,
    output logic                        init_done,
    output logic [15:0]                 conflict_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = (REQS > 1) ? $clog2(REQS) : 1;
    localparam logic [AW-1:0] LAST_BASE = AW'(DEPTH - PORTS);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          base_q, base_d;
    logic [RW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PORTS-1:0]       mem_en_q, mem_en_d;
    logic [PORTS*AW-1:0]    mem_addr_q, mem_addr_d;
    logic [PORTS*WIDTH-1:0] mem_d_q, mem_d_d;
    logic                   init_done_q, init_done_d;
    logic [REQS-1:0]        grant;
    logic [RW-1:0]          idx_r, last_idx;
    logic                   hit;
    int                     n_sel;
`ifdef LVT_SCHED_STATS_EN
    int                     n_conf;
    logic [16:0]            cnt_sum;
    logic [15:0]            conflict_cnt_q, conflict_cnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        rr_ptr_d    = rr_ptr_q;
        init_done_d = init_done_q;
        mem_en_d    = '0;
        mem_addr_d  = '0;
        mem_d_d     = '0;
        grant       = '0;
        idx_r       = '0;
        last_idx    = '0;
        hit         = 1'b0;
        n_sel       = 0;
`ifdef LVT_SCHED_STATS_EN
        n_conf      = 0;
`endif
        if (state_q == INIT) begin
            mem_en_d = '1;
            for (int p = 0; p < PORTS; p++)
                mem_addr_d[p*AW +: AW] = base_q + AW'(p);
            base_d = base_q + AW'(PORTS);
            if (base_q == LAST_BASE) begin
                state_d     = RUN;
                init_done_d = 1'b1;
                base_d      = '0;
            end
        end else begin
            // Ports already claimed this cycle double as the "selected" list for the address conflict check.
            for (int k = 0; k < REQS; k++) begin
                idx_r = RW'((int'(rr_ptr_q) + k) % REQS);
                if (bus.req_valid[idx_r]) begin
                    hit = 1'b0;
                    for (int p = 0; p < PORTS; p++)
                        if (mem_en_d[p] && (mem_addr_d[p*AW +: AW] == bus.req_addr[int'(idx_r)*AW +: AW]))
                            hit = 1'b1;
                    if (hit) begin
`ifdef LVT_SCHED_STATS_EN
                        n_conf = n_conf + 1;
`endif
                    end else if (n_sel < PORTS) begin
                        for (int p = 0; p < PORTS; p++) begin
                            if (p == n_sel) begin
                                mem_en_d[p]               = 1'b1;
                                mem_addr_d[p*AW +: AW]    = bus.req_addr[int'(idx_r)*AW +: AW];
                                mem_d_d[p*WIDTH +: WIDTH] = bus.req_data[int'(idx_r)*WIDTH +: WIDTH];
                            end
                        end
                        grant[idx_r] = 1'b1;
                        last_idx     = idx_r;
                        n_sel        = n_sel + 1;
                    end
                end
            end
            if (n_sel != 0)
                rr_ptr_d = (int'(last_idx) == REQS - 1) ? '0 : last_idx + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            base_q      <= '0;
            rr_ptr_q    <= '0;
            mem_en_q    <= '0;
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            rr_ptr_q    <= rr_ptr_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_d_q     <= mem_d_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef LVT_SCHED_STATS_EN
    always_comb begin
        cnt_sum        = {1'b0, conflict_cnt_q} + 17'(n_conf);
        conflict_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_cnt_q <= '0;
        else        conflict_cnt_q <= conflict_cnt_d;
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    assign conflict_cnt = '0;
`endif

    assign bus.req_ready = grant;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_d     = mem_d_q;
    assign init_done     = init_done_q;
endmodule

// File: tb/tb_lvt_write_scheduler.sv
// Directed, table-driven bench for lvt_write_scheduler (PORTS=2, REQS=4, DEPTH=16, WIDTH=8).
// Build with LVT_SCHED_STATS_EN defined to exercise the conflict counter and its saturation.
module tb_lvt_write_scheduler;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int PORTS = 2;
    localparam int REQS  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_done;
    logic [15:0] conflict_cnt;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    lvt_write_scheduler_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS)) bus ();

    lvt_write_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS), .REQS(REQS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .init_done    (init_done),
        .conflict_cnt (conflict_cnt)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  ready;
        logic [1:0]  en;
        logic [7:0]  maddr;
        logic [15:0] md;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge just after reset release. Requesters are kept valid to prove they are held off.
    task automatic init_check(input string tag);
        bus.req_valid = 4'b1111;
        bus.req_addr  = 16'h4321;
        bus.req_data  = 32'h44332211;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("%s_ready_c%0d", tag, k), 32'(bus.req_ready), 32'h0);
            @(posedge clk); #1;
            if (k == 8) bus.req_valid = 4'b0000;
            chk($sformatf("%s_en_c%0d", tag, k), 32'(bus.mem_en), 32'h3);
            chk($sformatf("%s_addr_c%0d", tag, k), 32'(bus.mem_addr),
                32'((((2*k) - 1) << 4) | ((2*k) - 2)));
            chk($sformatf("%s_d_c%0d", tag, k), 32'(bus.mem_d), 32'h0);
            chk($sformatf("%s_done_c%0d", tag, k), 32'(init_done), (k == 8) ? 32'h1 : 32'h0);
        end
    endtask

    initial begin
        // The table is sequential: each expectation assumes the rr_ptr left by the previous row.
        vecs[0]  = '{4'b1111, 16'h4321, 32'h44332211, 4'b0011, 2'b11, 8'h21, 16'h2211};
        vecs[1]  = '{4'b1100, 16'h4321, 32'h44332211, 4'b1100, 2'b11, 8'h43, 16'h4433};
        vecs[2]  = '{4'b0011, 16'h0055, 32'h0000BBAA, 4'b0001, 2'b01, 8'h05, 16'h00AA};
        vecs[3]  = '{4'b0010, 16'h0055, 32'h0000BBAA, 4'b0010, 2'b01, 8'h05, 16'h00BB};
        vecs[4]  = '{4'b1000, 16'h9000, 32'h5C000000, 4'b1000, 2'b01, 8'h09, 16'h005C};
        vecs[5]  = '{4'b0000, 16'h0000, 32'h00000000, 4'b0000, 2'b00, 8'h00, 16'h0000};
        vecs[6]  = '{4'b1111, 16'h7877, 32'h04030201, 4'b0101, 2'b11, 8'h87, 16'h0301};
        vecs[7]  = '{4'b1010, 16'h7877, 32'h04030201, 4'b1000, 2'b01, 8'h07, 16'h0004};
        vecs[8]  = '{4'b0010, 16'h7877, 32'h04030201, 4'b0010, 2'b01, 8'h07, 16'h0002};
        vecs[9]  = '{4'b0111, 16'h0CBA, 32'h001C1B1A, 4'b0101, 2'b11, 8'hAC, 16'h1A1C};
        vecs[10] = '{4'b0010, 16'h0CBA, 32'h001C1B1A, 4'b0010, 2'b01, 8'h0B, 16'h001B};

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        #2;
        chk("rst_en",    32'(bus.mem_en),    32'h0);
        chk("rst_addr",  32'(bus.mem_addr),  32'h0);
        chk("rst_d",     32'(bus.mem_d),     32'h0);
        chk("rst_done",  32'(init_done),     32'h0);
        chk("rst_cnt",   32'(conflict_cnt),  32'h0);

        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        init_check("init");

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.req_valid = vecs[i].valid;
            bus.req_addr  = vecs[i].addr;
            bus.req_data  = vecs[i].data;
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(vecs[i].ready));
            @(posedge clk); #1;
            chk($sformatf("v%0d_en", i),    32'(bus.mem_en),   32'(vecs[i].en));
            chk($sformatf("v%0d_addr", i),  32'(bus.mem_addr), 32'(vecs[i].maddr));
            chk($sformatf("v%0d_d", i),     32'(bus.mem_d),    32'(vecs[i].md));
        end
        bus.req_valid = '0;
`ifdef LVT_SCHED_STATS_EN
        chk("cnt_after_table", 32'(conflict_cnt), 32'd4);
`else
        chk("cnt_after_table", 32'(conflict_cnt), 32'd0);
`endif

        // Reset pulse during the fourth INIT cycle must clear outputs at once and restart at address 0.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_init_en_before", 32'(bus.mem_en), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en",   32'(bus.mem_en),   32'h0);
        chk("mid_rst_addr", 32'(bus.mem_addr), 32'h0);
        chk("mid_rst_done", 32'(init_done),    32'h0);
        chk("mid_rst_cnt",  32'(conflict_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        init_check("reinit");

        // All four requesters target one address: one grant and three conflicts per cycle.
        @(negedge clk);
        bus.req_valid = 4'b1111;
        bus.req_addr  = 16'h3333;
        bus.req_data  = 32'h0D0C0B0A;
        #1;
        chk("same_addr_ready", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #1;
        chk("same_addr_en",   32'(bus.mem_en),   32'b01);
        chk("same_addr_addr", 32'(bus.mem_addr), 32'h03);
        chk("same_addr_d",    32'(bus.mem_d),    32'h000A);
`ifdef LVT_SCHED_STATS_EN
        chk("same_addr_cnt", 32'(conflict_cnt), 32'd3);
        repeat (22000) @(posedge clk);
        #1;
        chk("cnt_saturated", 32'(conflict_cnt), 32'hFFFF);
`else
        chk("same_addr_cnt", 32'(conflict_cnt), 32'd0);
`endif
        bus.req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lvt_write_scheduler.md
LVT_WRITE_SCHEDULER -- requirements
Module: lvt_write_scheduler

Interface
REQ-001 Parameter WIDTH, default 32, data width of each LVT memory port.
REQ-002 Parameter DEPTH, default 1024, word count of LVT memory; SHALL be a multiple of PORTS; AW = $clog2(DEPTH).
REQ-003 Parameter PORTS, default 2, number of LVT memory write ports driven.
REQ-004 Parameter REQS, default 4, number of requesters sharing the ports; REQS >= PORTS.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  REQS  per-requester write request.
REQ-008 req_addr  input  REQS*AW  packed addresses; requester i at bits [(i+1)*AW-1 -: AW].
REQ-009 req_data  input  REQS*WIDTH  packed write data, same packing.
REQ-010 req_ready  output  REQS  per-requester grant, combinational.
REQ-011 mem_en  output  PORTS  registered write enable per memory port.
REQ-012 mem_addr  output  PORTS*AW  registered packed port addresses.
REQ-013 mem_d  output  PORTS*WIDTH  registered packed port write data.
REQ-014 init_done  output  1  high once post-reset clear is complete.
REQ-015 conflict_cnt  output  16  saturating count of same-address conflicts (see Configuration).

Function
REQ-016 FSM states SHALL be INIT and RUN; reset enters INIT.
REQ-017 INIT: each cycle all mem_en SHALL be high, port p writes address base+p with mem_d = 0; base starts at 0, steps by PORTS.
REQ-018 INIT -> RUN SHALL occur after the cycle in which base = DEPTH-PORTS is issued (DEPTH/PORTS write cycles); init_done rises with RUN entry and stays high until reset.
REQ-019 In INIT, req_ready SHALL be all-zero.
REQ-020 RUN: scan requesters round-robin from pointer rr_ptr; grant first up to PORTS valid requesters in scan order.
REQ-021 A valid requester whose req_addr equals that of an already-selected requester in the same cycle SHALL NOT be granted and SHALL count one conflict.
REQ-022 req_ready[i] SHALL be high only when req_valid[i] is high and i is granted; transfer occurs when both high.
REQ-023 k-th granted requester (scan order) SHALL drive port k; unused ports SHALL have mem_en = 0, mem_addr and mem_d = 0.
REQ-024 Port outputs SHALL be registered: grant in cycle N -> mem_en/mem_addr/mem_d valid in cycle N+1 (latency 1).
REQ-025 rr_ptr SHALL advance to (last granted index + 1) mod REQS; unchanged if no grant.
REQ-026 Requesters SHALL NOT make req_valid depend on req_ready; req_valid/addr/data SHALL remain stable until transfer.

Reset
REQ-027 On rst_n low, asynchronously: mem_en, mem_addr, mem_d, init_done, conflict_cnt = 0; rr_ptr = 0; base = 0; state = INIT.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL abort operation; after release clearing restarts at address 0.

Configuration
REQ-029 Macro LVT_SCHED_STATS_EN: when defined, conflict_cnt SHALL increment by number of conflicts per RUN cycle, saturating at 16'hFFFF.
REQ-030 Without LVT_SCHED_STATS_EN, conflict_cnt SHALL be tied to 0, no counter logic; grant behaviour unchanged.

Verification (PORTS=2, REQS=4, DEPTH=16, WIDTH=8)
REQ-031 Release rst_n -> 8 cycles mem_en=2'b11, addresses (0,1),(2,3)..(14,15), mem_d=0; req_ready=0 throughout; init_done=1 on 9th cycle.
REQ-032 RUN, rr_ptr=0, all 4 valid, addrs 1,2,3,4 -> cycle N req_ready=4'b0011, N+1 ports (1,2); then req_ready=4'b1100, ports (3,4); rr_ptr returns 0.
REQ-033 req0 and req1 valid, both addr 5, data 0xAA/0xBB -> req_ready=4'b0001, port0 addr 5 data 0xAA, mem_en=2'b01; next cycle req1 granted; conflict_cnt=1 with macro, 0 without.
REQ-034 Only req3 valid, addr 9, data 0x5C -> req_ready=4'b1000; next cycle mem_en=2'b01, port0 addr 9 data 0x5C; rr_ptr=0.
REQ-035 rst_n pulsed low during INIT cycle 4 -> outputs 0 immediately; after release INIT restarts at (0,1), 8 full cycles before init_done.
REQ-036 With macro, force 65536 conflicts -> conflict_cnt holds 16'hFFFF.
